s3g_rx_mb: RTL and testbench
============================

# s3g_rx_mb

Parametrised S3G packet receiver with a multi-slot payload store. It sits between the UART byte receiver and the executor. It parses the 0xD5 / length / payload / CRC8 framing, checks the length and the Dallas/Maxim CRC8, and enforces an inter-byte timeout. Good packets are committed into one of NBUF slots, so the UART can keep receiving while the executor consumes earlier packets through a ready/ack handshake and a byte-addressed read port.

## Interface

Parameters:
- MAX_PAYLOAD, 32: maximum payload bytes per packet (1..255); slot depth.
- NBUF, 2: number of packet slots; power of two, ≥1.
- TIMEOUT, 100000: maximum cycles between consecutive bytes inside a packet; 0 disables the timeout.

Derived widths:
- AW = clog2(MAX_PAYLOAD).
- BW = clog2(NBUF), min 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_data  in  8  received byte; valid when rx_done=1.
- rx_done  in  1  one-cycle strobe per received byte.
- packet_done  out  1  one-cycle pulse when a good packet is committed.
- packet_error  out  1  one-cycle pulse when a packet is rejected.
- err_code  out  3  cause of the last rejection; 0 none, 1 LEN, 2 CRC, 3 TIMEOUT, 4 FULL.
- pkt_valid  out  1  head slot holds an unconsumed packet.
- pkt_len  out  8  payload length of the head packet.
- pkt_rd_addr  in  AW  byte index into the head packet.
- pkt_rd_data  out  8  head packet byte at pkt_rd_addr; registered.
- pkt_ack  in  1  release the head slot.
- pkt_count  out  BW+1  number of committed, unacked packets.

## Operation

Parser FSM. All transitions happen only on rx_done, except the timeout.
- IDLE
  - 0xD5 → LEN.
  - Any other byte is ignored silently; no error.
  - On entry to LEN, latch full = (pkt_count == NBUF).
- LEN
  - Byte 0 or byte > MAX_PAYLOAD → packet_error, err_code=1, → IDLE.
  - Otherwise store the length, clear CRC and byte index, → PAYLOAD.
- PAYLOAD
  - Each byte updates the CRC.
  - If not full, each byte is written to slot wr_ptr at the current index; the index increments.
  - After the length-th byte → CHECK.
- CHECK (the next byte is the CRC byte)
  - If full → error, err_code=4.
  - Else if the byte ≠ computed CRC → error, err_code=2.
  - Else commit: store the length for the slot, wr_ptr+1 mod NBUF, pkt_count+1, packet_done.
  - In every case → IDLE.
- CRC8 (Dallas/Maxim, iButton)
  - Reflected polynomial 0x8C, init 0x00, processed LSB first.
  - Computed over payload bytes only, never over 0xD5 or the length byte.
- Timeout
  - In LEN, PAYLOAD or CHECK, a counter is cleared on every rx_done and increments otherwise.
  - Reaching TIMEOUT → packet_error, err_code=3, → IDLE; partial data is discarded.
- Consumer side
  - pkt_ack while pkt_valid → rd_ptr+1 mod NBUF, pkt_count−1.
  - pkt_ack while !pkt_valid is ignored.
  - pkt_valid = (pkt_count ≠ 0).
  - pkt_len and pkt_rd_data always refer to the slot at rd_ptr.
- err_code holds its value until the next packet_error. A packet_done does not clear it.
- Reset values
  - All outputs 0: packet_done, packet_error, err_code, pkt_valid, pkt_len, pkt_rd_data, pkt_count.
  - FSM in IDLE; rd_ptr = wr_ptr = 0.
  - Slot memory is not cleared.
- Reset mid-packet discards the packet in progress and all stored packets.

## Timing

- packet_done and packet_error are asserted in the cycle after the rx_done that caused them.
- LEN errors fire one cycle after the length byte; the bench does not wait for further bytes.
- On commit, pkt_valid, pkt_len and pkt_count update in the same cycle as packet_done.
- pkt_rd_data is valid one cycle after pkt_rd_addr changes.
  - It also reflects the new head one cycle after an ack, provided pkt_rd_addr is held.
- Commit and ack in the same cycle: both take effect, pkt_count is unchanged, and pkt_valid stays 1.
- A slot freed by an ack during a packet that was latched as full does not rescue that packet; it still ends with FULL.
- Back-to-back bytes (rx_done on consecutive cycles) are accepted in every state.
- A TIMEOUT error fires exactly TIMEOUT cycles after the last rx_done.

## Test plan

1. Good packet: D5 03 01 02 03 D8 → packet_done; pkt_valid=1; pkt_len=3; pkt_count=1; addresses 0/1/2 read 01/02/03.
2. Bad CRC: D5 03 01 02 03 CC → packet_error; err_code=2; pkt_count unchanged.
3. Resync and zero CRC seed:
   - Stimulus: 0D, then D5 03 00 01 02 78.
   - Response: the 0D is ignored with no error; the packet is accepted with len 3 and data 00 01 02.
4. Full (NBUF=2):
   - Stimulus: two good packets with no ack, then a third good packet.
   - Response: err_code=4 and pkt_count stays 2.
   - Then pkt_ack → the head becomes the second packet, pkt_count=1.
   - A commit and an ack in the same cycle leave pkt_count=1.
5. Length and timeout (MAX_PAYLOAD=32):
   - D5 40 → err_code=1, one cycle after the length byte.
   - D5 02 01, then silence for TIMEOUT cycles → err_code=3, then a good packet is accepted.
6. Reset mid-payload:
   - Stimulus: assert rst after D5 03 01, with one packet already stored.
   - Response: all outputs return to 0 and pkt_valid=0.
   - A following D5 03 01 02 03 D8 is accepted into slot 0.

Source files
------------

// File: rtl/s3g_rx_mb.sv
// s3g_rx_mb: S3G packet receiver (0xD5 / length / payload / CRC8 framing)
// with an NBUF-slot payload store drained through a ready/ack handshake
// and a registered byte-addressed read port.
module s3g_rx_mb #(
    parameter int MAX_PAYLOAD = 32,
    parameter int NBUF        = 2,
    parameter int TIMEOUT     = 100000,
    localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1,
    localparam int BW = (NBUF > 1) ? $clog2(NBUF) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    output logic          packet_done,
    output logic          packet_error,
    output logic [2:0]    err_code,
    output logic          pkt_valid,
    output logic [7:0]    pkt_len,
    input  logic [AW-1:0] pkt_rd_addr,
    output logic [7:0]    pkt_rd_data,
    input  logic          pkt_ack,
    output logic [BW:0]   pkt_count
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_LEN     = 2'd1;
    localparam logic [1:0] ST_PAYLOAD = 2'd2;
    localparam logic [1:0] ST_CHECK   = 2'd3;

    localparam logic [2:0] ERR_LEN     = 3'd1;
    localparam logic [2:0] ERR_CRC     = 3'd2;
    localparam logic [2:0] ERR_TIMEOUT = 3'd3;
    localparam logic [2:0] ERR_FULL    = 3'd4;

    localparam logic [7:0]  MAXP  = 8'(MAX_PAYLOAD);
    localparam logic [31:0] TO    = 32'(TIMEOUT);
    localparam logic [BW:0] NFULL = (BW+1)'(NBUF);
    localparam logic [BW:0] ONE   = (BW+1)'(1);

    logic [1:0]    state;
    logic          full;
    logic [7:0]    len_r;
    logic [7:0]    idx;
    logic [7:0]    crc;
    logic [31:0]   tcnt;
    logic [BW-1:0] wr_ptr;
    logic [BW-1:0] rd_ptr;

    logic [7:0] mem      [NBUF][2**AW];
    logic [7:0] slot_len [NBUF];

    logic commit;
    logic ack_ok;
    logic mem_we;
    logic timeout_hit;

    // Dallas/Maxim CRC8: reflected poly 0x8C, LSB first
    function automatic logic [7:0] crc8_byte(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        logic [7:0] b;
        logic       mix;
        r = c;
        b = d;
        for (int unsigned i = 0; i < 8; i++) begin
            mix = r[0] ^ b[0];
            r   = r >> 1;
            if (mix) r = r ^ 8'h8C;
            b   = b >> 1;
        end
        return r;
    endfunction

    function automatic logic [BW-1:0] ptr_inc(input logic [BW-1:0] p);
        return (p == BW'(NBUF - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake and write-enable decode for the current cycle
    always_comb begin
        commit      = rx_done && (state == ST_CHECK) && !full && (rx_data == crc);
        ack_ok      = pkt_ack && pkt_valid;
        mem_we      = rx_done && (state == ST_PAYLOAD) && !full;
        timeout_hit = (TIMEOUT != 0) && (tcnt == TO - 32'd1);
    end

    assign pkt_valid = (pkt_count != '0);
    assign pkt_len   = slot_len[rd_ptr];

    // Payload store: written while parsing, never reset
    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr][idx[AW-1:0]] <= rx_data;
    end

    // Parser FSM, slot bookkeeping and registered read port
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            full         <= 1'b0;
            len_r        <= '0;
            idx          <= '0;
            crc          <= '0;
            tcnt         <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            pkt_count    <= '0;
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            err_code     <= '0;
            pkt_rd_data  <= '0;
            for (int unsigned i = 0; i < NBUF; i++) slot_len[i] <= '0;
        end else begin
            packet_done  <= 1'b0;
            packet_error <= 1'b0;
            pkt_rd_data  <= mem[rd_ptr][pkt_rd_addr];

            // Commit and ack in the same cycle cancel out in the count
            if (commit && !ack_ok)      pkt_count <= pkt_count + ONE;
            else if (!commit && ack_ok) pkt_count <= pkt_count - ONE;
            if (ack_ok) rd_ptr <= ptr_inc(rd_ptr);

            if (rx_done) begin
                tcnt <= '0;
                case (state)
                    ST_IDLE: begin
                        if (rx_data == 8'hD5) begin
                            state <= ST_LEN;
                            full  <= (pkt_count == NFULL);
                        end
                    end
                    ST_LEN: begin
                        if (rx_data == 8'h00 || rx_data > MAXP) begin
                            packet_error <= 1'b1;
                            err_code     <= ERR_LEN;
                            state        <= ST_IDLE;
                        end else begin
                            len_r <= rx_data;
                            idx   <= '0;
                            crc   <= '0;
                            state <= ST_PAYLOAD;
                        end
                    end
                    ST_PAYLOAD: begin
                        crc <= crc8_byte(crc, rx_data);
                        idx <= idx + 8'd1;
                        if (idx == len_r - 8'd1) state <= ST_CHECK;
                    end
                    default: begin
                        if (full) begin
                            packet_error <= 1'b1;
                            err_code     <= ERR_FULL;
                        end else if (rx_data != crc) begin
                            packet_error <= 1'b1;
                            err_code     <= ERR_CRC;
                        end else begin
                            slot_len[wr_ptr] <= len_r;
                            wr_ptr           <= ptr_inc(wr_ptr);
                            packet_done      <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                endcase
            end else if (state != ST_IDLE) begin
                if (timeout_hit) begin
                    packet_error <= 1'b1;
                    err_code     <= ERR_TIMEOUT;
                    state        <= ST_IDLE;
                    tcnt         <= '0;
                end else begin
                    tcnt <= tcnt + 32'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_s3g_rx_mb.sv
// tb_s3g_rx_mb: directed self-checking bench for s3g_rx_mb
// (MAX_PAYLOAD=32, NBUF=2, TIMEOUT=20).
module tb_s3g_rx_mb;

    localparam int TMO = 20;

    logic       clk;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       packet_done;
    logic       packet_error;
    logic [2:0] err_code;
    logic       pkt_valid;
    logic [7:0] pkt_len;
    logic [4:0] pkt_rd_addr;
    logic [7:0] pkt_rd_data;
    logic       pkt_ack;
    logic [1:0] pkt_count;

    int vectors;
    int miscompares;

    s3g_rx_mb #(.MAX_PAYLOAD(32), .NBUF(2), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .rx_data      (rx_data),
        .rx_done      (rx_done),
        .packet_done  (packet_done),
        .packet_error (packet_error),
        .err_code     (err_code),
        .pkt_valid    (pkt_valid),
        .pkt_len      (pkt_len),
        .pkt_rd_addr  (pkt_rd_addr),
        .pkt_rd_data  (pkt_rd_data),
        .pkt_ack      (pkt_ack),
        .pkt_count    (pkt_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All tasks start and end 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    // Packet A: 01 02 03, CRC D8
    task automatic send_pkt_a();
        send_byte(8'hD5); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hD8);
    endtask

    // Packet B: 00 01 02, CRC 78
    task automatic send_pkt_b();
        send_byte(8'hD5); send_byte(8'h03);
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h02);
        send_byte(8'h78);
    endtask

    task automatic read_byte(input logic [4:0] a, input logic [7:0] exp, input string name);
        pkt_rd_addr = a;
        tick();
        vectors++;
        if (pkt_rd_data !== exp) begin
            miscompares++;
            $display("FAIL %s: pkt_rd_data=%02h expected %02h", name, pkt_rd_data, exp);
        end
    endtask

    task automatic ack_once();
        pkt_ack = 1'b1;
        tick();
        pkt_ack = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        vectors++;
        if ({packet_done, packet_error, err_code, pkt_valid, pkt_len, pkt_rd_data, pkt_count} !== '0) begin
            miscompares++;
            $display("FAIL reset: done=%b err=%b code=%0d valid=%b len=%0d rd=%02h cnt=%0d expected all 0",
                     packet_done, packet_error, err_code, pkt_valid, pkt_len, pkt_rd_data, pkt_count);
        end
    endtask

    task automatic test_good_packet();
        send_pkt_a();
        vectors++;
        if ({packet_done, packet_error, pkt_valid, pkt_len, pkt_count, err_code} !== {1'b1, 1'b0, 1'b1, 8'd3, 2'd1, 3'd0}) begin
            miscompares++;
            $display("FAIL good_commit: done=%b err=%b valid=%b len=%0d cnt=%0d code=%0d expected 1 0 1 3 1 0",
                     packet_done, packet_error, pkt_valid, pkt_len, pkt_count, err_code);
        end
        tick();
        vectors++;
        if (packet_done !== 1'b0) begin
            miscompares++;
            $display("FAIL good_pulse: packet_done=%b expected 0", packet_done);
        end
        read_byte(5'd0, 8'h01, "good_rd0");
        read_byte(5'd1, 8'h02, "good_rd1");
        read_byte(5'd2, 8'h03, "good_rd2");
        ack_once();
        vectors++;
        if ({pkt_valid, pkt_count} !== {1'b0, 2'd0}) begin
            miscompares++;
            $display("FAIL good_ack: valid=%b cnt=%0d expected 0 0", pkt_valid, pkt_count);
        end
        ack_once();
        vectors++;
        if (pkt_count !== 2'd0) begin
            miscompares++;
            $display("FAIL ack_empty: cnt=%0d expected 0", pkt_count);
        end
    endtask

    task automatic test_bad_crc();
        send_byte(8'hD5); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        send_byte(8'hCC);
        vectors++;
        if ({packet_error, packet_done, err_code, pkt_count} !== {1'b1, 1'b0, 3'd2, 2'd0}) begin
            miscompares++;
            $display("FAIL bad_crc: err=%b done=%b code=%0d cnt=%0d expected 1 0 2 0",
                     packet_error, packet_done, err_code, pkt_count);
        end
    endtask

    task automatic test_resync();
        send_byte(8'h0D);
        vectors++;
        if ({packet_error, packet_done} !== 2'b00) begin
            miscompares++;
            $display("FAIL resync_ignore: err=%b done=%b expected 0 0", packet_error, packet_done);
        end
        send_pkt_b();
        vectors++;
        if ({packet_done, pkt_len, pkt_count, err_code} !== {1'b1, 8'd3, 2'd1, 3'd2}) begin
            miscompares++;
            $display("FAIL resync_commit: done=%b len=%0d cnt=%0d code=%0d expected 1 3 1 2",
                     packet_done, pkt_len, pkt_count, err_code);
        end
        read_byte(5'd0, 8'h00, "resync_rd0");
        read_byte(5'd1, 8'h01, "resync_rd1");
        read_byte(5'd2, 8'h02, "resync_rd2");
        ack_once();
    endtask

    task automatic test_full();
        send_pkt_a();
        send_pkt_b();
        vectors++;
        if (pkt_count !== 2'd2) begin
            miscompares++;
            $display("FAIL full_two: cnt=%0d expected 2", pkt_count);
        end
        send_pkt_a();
        vectors++;
        if ({packet_error, packet_done, err_code, pkt_count} !== {1'b1, 1'b0, 3'd4, 2'd2}) begin
            miscompares++;
            $display("FAIL full_reject: err=%b done=%b code=%0d cnt=%0d expected 1 0 4 2",
                     packet_error, packet_done, err_code, pkt_count);
        end
        read_byte(5'd0, 8'h01, "full_head_a");
        ack_once();
        vectors++;
        if ({pkt_count, pkt_valid} !== {2'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL full_ack: cnt=%0d valid=%b expected 1 1", pkt_count, pkt_valid);
        end
        tick();
        vectors++;
        if (pkt_rd_data !== 8'h00) begin
            miscompares++;
            $display("FAIL full_head_b: pkt_rd_data=%02h expected 00", pkt_rd_data);
        end
        // Commit packet A while acking packet B in the same cycle
        send_byte(8'hD5); send_byte(8'h03);
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        rx_data = 8'hD8;
        rx_done = 1'b1;
        pkt_ack = 1'b1;
        tick();
        rx_done = 1'b0;
        pkt_ack = 1'b0;
        vectors++;
        if ({packet_done, pkt_count, pkt_valid, pkt_len} !== {1'b1, 2'd1, 1'b1, 8'd3}) begin
            miscompares++;
            $display("FAIL commit_ack: done=%b cnt=%0d valid=%b len=%0d expected 1 1 1 3",
                     packet_done, pkt_count, pkt_valid, pkt_len);
        end
        tick();
        vectors++;
        if (pkt_rd_data !== 8'h01) begin
            miscompares++;
            $display("FAIL commit_ack_head: pkt_rd_data=%02h expected 01", pkt_rd_data);
        end
        ack_once();
    endtask

    task automatic test_len_timeout();
        logic early;
        send_byte(8'hD5); send_byte(8'h40);
        vectors++;
        if ({packet_error, err_code} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL len_big: err=%b code=%0d expected 1 1", packet_error, err_code);
        end
        send_byte(8'hD5); send_byte(8'h21);
        vectors++;
        if ({packet_error, err_code} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL len_33: err=%b code=%0d expected 1 1", packet_error, err_code);
        end
        send_byte(8'hD5); send_byte(8'h00);
        vectors++;
        if ({packet_error, err_code} !== {1'b1, 3'd1}) begin
            miscompares++;
            $display("FAIL len_zero: err=%b code=%0d expected 1 1", packet_error, err_code);
        end
        send_byte(8'hD5); send_byte(8'h02); send_byte(8'h01);
        early = 1'b0;
        for (int i = 1; i < TMO; i++) begin
            tick();
            if (packet_error !== 1'b0) early = 1'b1;
        end
        vectors++;
        if (early !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_early: error seen=%b expected 0", early);
        end
        tick();
        vectors++;
        if ({packet_error, err_code} !== {1'b1, 3'd3}) begin
            miscompares++;
            $display("FAIL timeout: err=%b code=%0d expected 1 3", packet_error, err_code);
        end
        send_pkt_a();
        vectors++;
        if ({packet_done, pkt_count} !== {1'b1, 2'd1}) begin
            miscompares++;
            $display("FAIL timeout_recover: done=%b cnt=%0d expected 1 1", packet_done, pkt_count);
        end
        ack_once();
    endtask

    task automatic test_reset_mid();
        send_pkt_b();
        send_byte(8'hD5); send_byte(8'h03); send_byte(8'h01);
        rst = 1'b1;
        #2;
        vectors++;
        if ({packet_done, packet_error, err_code, pkt_valid, pkt_len, pkt_rd_data, pkt_count} !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: done=%b err=%b code=%0d valid=%b len=%0d rd=%02h cnt=%0d expected all 0",
                     packet_done, packet_error, err_code, pkt_valid, pkt_len, pkt_rd_data, pkt_count);
        end
        tick();
        rst = 1'b0;
        tick();
        send_pkt_a();
        vectors++;
        if ({packet_done, pkt_count, pkt_len, err_code} !== {1'b1, 2'd1, 8'd3, 3'd0}) begin
            miscompares++;
            $display("FAIL reset_recover: done=%b cnt=%0d len=%0d code=%0d expected 1 1 3 0",
                     packet_done, pkt_count, pkt_len, err_code);
        end
        read_byte(5'd2, 8'h03, "reset_rd2");
        ack_once();
        send_pkt_b();
        read_byte(5'd0, 8'h00, "reset_slot1");
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        rx_data     = '0;
        rx_done     = 1'b0;
        pkt_rd_addr = '0;
        pkt_ack     = 1'b0;
        test_reset();
        test_good_packet();
        test_bad_crc();
        test_resync();
        test_full();
        test_len_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
